reg_file: RTL and testbench

//  Multi-cycle CPU general-purpose register file: 32 x 32-bit registers, two

---
 rtl/reg_file.sv | 116 +++++++++++
 tb/tb_reg_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Multi-cycle CPU register file: 2**ADDR_W x DATA_W, two operand read ports plus a
// display read port, one write-back port with internal index/data select muxes.
module reg_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              wr_commit,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rdata
);
    // $0 is forced here so its stored bits never reach an output.
    always_comb begin
        rdata = mem_q;
        if (idx == '0)
            rdata = '0;
        else if (BYPASS && wr_commit && (idx == wr_idx))
            rdata = wd;
    end
endmodule

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWre,
    input  logic [1:0]        RegDst,
    input  logic [1:0]        WrRegDSrc,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] pc4,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] wr_index
);
    localparam int NREG   = 1 << ADDR_W;
    localparam int NUM_RD = 3;

    typedef struct packed {
        logic              commit;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    logic [DATA_W-1:0] regs [NREG];
    wr_req_t           wr;
    logic [DATA_W-1:0] wd;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_idx;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_q;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    always_comb begin
        wr_index = '0;
        case (RegDst)
            2'b00:   wr_index = ADDR_W'(NREG - 1);
            2'b01:   wr_index = rt;
            2'b10:   wr_index = rd;
            default: wr_index = '0;
        endcase
    end

    always_comb begin
        wd = alu_result;
        case (WrRegDSrc)
            2'b00:   wd = pc4;
            2'b10:   wd = mem_data;
            default: wd = alu_result;
        endcase
    end

    // Reset masks the commit so neither storage nor bypass sees the pending write.
    always_comb begin
        wr.commit = !RST && RegWre && (RegDst != 2'b11) && (wr_index != '0);
        wr.idx    = wr_index;
        wr.data   = wd;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr.commit) begin
            regs[wr.idx] <= wr.data;
        end
    end

    assign rd_idx = {dbg_addr, rt, rs};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_q[p] = regs[rd_idx[p]];
        reg_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port (
            .idx      (rd_idx[p]),
            .mem_q    (rd_q[p]),
            .wr_commit(wr.commit),
            .wr_idx   (wr.idx),
            .wd       (wr.data),
            .rdata    (rd_data[p])
        );
    end

    assign read_data1 = rd_data[0];
    assign read_data2 = rd_data[1];
    assign dbg_data   = rd_data[2];
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench: stimulus queues expected port values, a negedge monitor compares.
module tb_reg_file;
    logic        CLK = 1'b0;
    logic        RST, RegWre;
    logic [1:0]  RegDst, WrRegDSrc;
    logic [4:0]  rs, rt, rd, dbg_addr;
    logic [31:0] pc4, alu_result, mem_data;
    logic [31:0] a_rd1, a_rd2, a_dbg, b_rd1, b_rd2, b_dbg;
    logic [4:0]  a_widx, b_widx;

    always #5 CLK = ~CLK;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .CLK(CLK), .RST(RST), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .rs(rs), .rt(rt), .rd(rd), .pc4(pc4), .alu_result(alu_result), .mem_data(mem_data),
        .dbg_addr(dbg_addr), .read_data1(a_rd1), .read_data2(a_rd2), .dbg_data(a_dbg),
        .wr_index(a_widx));

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nobyp (
        .CLK(CLK), .RST(RST), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .rs(rs), .rt(rt), .rd(rd), .pc4(pc4), .alu_result(alu_result), .mem_data(mem_data),
        .dbg_addr(dbg_addr), .read_data1(b_rd1), .read_data2(b_rd2), .dbg_data(b_dbg),
        .wr_index(b_widx));

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    // port: 0..3 = bypass DUT rd1/rd2/dbg/widx, 4..7 = non-bypass DUT same order
    task automatic exp(input string name, input int port, input logic [31:0] val);
        exp_t e;
        e.name = name; e.port = port; e.val = val;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge CLK);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.port)
                    0: act = a_rd1;
                    1: act = a_rd2;
                    2: act = a_dbg;
                    3: act = {27'd0, a_widx};
                    4: act = b_rd1;
                    5: act = b_rd2;
                    6: act = b_dbg;
                    default: act = {27'd0, b_widx};
                endcase
                n_chk++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.val);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; RegWre = 1'b0; RegDst = 2'b00; WrRegDSrc = 2'b00;
        rs = '0; rt = '0; rd = '0; dbg_addr = '0;
        pc4 = '0; alu_result = '0; mem_data = '0;
        tick();

        // 1. reset state
        RST = 1'b0; rs = 5'd5; rt = 5'd31; dbg_addr = 5'd7;
        exp("rst_rd1", 0, 32'h0); exp("rst_rd2", 1, 32'h0); exp("rst_dbg", 2, 32'h0);
        exp("rst_widx", 3, 32'd31); exp("rst_rd2_nb", 5, 32'h0);
        tick();

        // 2. rd write of alu_result, bypass visible only on the BYPASS=1 DUT
        RegWre = 1'b1; RegDst = 2'b10; rd = 5'd8; WrRegDSrc = 2'b01;
        alu_result = 32'hDEAD_BEEF; rs = 5'd8;
        exp("wr8_widx", 3, 32'd8); exp("wr8_byp", 0, 32'hDEAD_BEEF); exp("wr8_nobyp", 4, 32'h0);
        tick();
        RegWre = 1'b0;
        exp("rd8", 0, 32'hDEAD_BEEF); exp("rd8_nb", 4, 32'hDEAD_BEEF);
        tick();

        // 3. jal link to $31
        RegWre = 1'b1; RegDst = 2'b00; WrRegDSrc = 2'b00; pc4 = 32'h0000_0104;
        exp("jal_widx", 7, 32'd31);
        tick();
        RegWre = 1'b0; rt = 5'd31;
        exp("jal_rd2", 1, 32'h0000_0104); exp("jal_rd2_nb", 5, 32'h0000_0104);
        tick();

        // 4. write to $0 dropped, including bypass
        RegWre = 1'b1; RegDst = 2'b01; rt = 5'd0; WrRegDSrc = 2'b10;
        mem_data = 32'h1234_5678; rs = 5'd0;
        exp("r0_widx", 3, 32'd0); exp("r0_byp_rd1", 0, 32'h0); exp("r0_byp_rd2", 1, 32'h0);
        tick();
        RegWre = 1'b0;
        exp("r0_rd1", 0, 32'h0); exp("r0_rd1_nb", 4, 32'h0);
        tick();

        // mem_data via rt, and alu_result via code 11
        RegWre = 1'b1; RegDst = 2'b01; rt = 5'd10; WrRegDSrc = 2'b10;
        tick();
        RegDst = 2'b10; rd = 5'd11; WrRegDSrc = 2'b11; alu_result = 32'hCAFE_0011;
        tick();
        RegWre = 1'b0; dbg_addr = 5'd10; rs = 5'd11;
        exp("mem_dbg", 2, 32'h1234_5678); exp("mem_dbg_nb", 6, 32'h1234_5678);
        exp("src11_rd1", 0, 32'hCAFE_0011);
        tick();

        // 5. bypass with both ports (and display) on the write target
        RegWre = 1'b1; RegDst = 2'b10; rd = 5'd9; WrRegDSrc = 2'b01; alu_result = 32'h1;
        tick();
        alu_result = 32'hA5A5_A5A5; rs = 5'd9; rt = 5'd9; dbg_addr = 5'd9;
        exp("byp_rd1", 0, 32'hA5A5_A5A5); exp("byp_rd2", 1, 32'hA5A5_A5A5);
        exp("byp_dbg", 2, 32'hA5A5_A5A5);
        exp("nob_rd1", 4, 32'h1); exp("nob_rd2", 5, 32'h1); exp("nob_dbg", 6, 32'h1);
        tick();
        RegWre = 1'b0;
        exp("nob_rd1_after", 4, 32'hA5A5_A5A5); exp("nob_rd2_after", 5, 32'hA5A5_A5A5);
        tick();

        // 6. reset priority over a same-cycle write
        RegWre = 1'b1; RegDst = 2'b10; rd = 5'd4; alu_result = 32'h77;
        tick();
        RST = 1'b1; alu_result = 32'h55; rs = 5'd4; rt = 5'd8;
        exp("rstw_nobyp", 0, 32'h77);
        tick();
        RST = 1'b0; RegWre = 1'b0;
        exp("rstw_r4", 0, 32'h0); exp("rstw_r8", 1, 32'h0); exp("rstw_r4_nb", 4, 32'h0);
        tick();

        // RegDst=11 suppresses the write
        RegWre = 1'b1; RegDst = 2'b01; rt = 5'd5; alu_result = 32'h11;
        tick();
        RegDst = 2'b11; alu_result = 32'h99; rs = 5'd5;
        exp("sup_widx", 3, 32'd0); exp("sup_byp", 0, 32'h11);
        tick();
        RegWre = 1'b0;
        exp("sup_r5", 0, 32'h11); exp("sup_r5_nb", 5, 32'h11);
        tick();

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: got no finish expected finish by 100000");
            $fatal(1, "timeout");
        end
    end
endmodule
